// File: rtl/dac_i2s_tx.sv
// Stereo I2S transmitter: 16-bit L/R frames from a small FIFO, serialised MSB-first
// with the one-bit I2S delay. All bit clocks come from one free-running counter.
module dac_i2s_tx #(
    parameter int MCLK_SH = 1,
    parameter int SCLK_SH = 3,
    parameter int FDEPTH  = 4
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic [15:0] snd_l,
    input  logic [15:0] snd_r,
    input  logic        snd_we,
    output logic        snd_rdy,
    input  logic        mute,
    input  logic        clr,
    output logic        underrun,
    output logic        dac_mclk,
    output logic        dac_sclk,
    output logic        dac_lrck,
    output logic        dac_sdin
);

    localparam int CW = SCLK_SH + 6;
    localparam int AW = $clog2(FDEPTH);

    logic [CW-1:0] ctr;
    logic [CW-1:0] ctr_nxt;
    logic          frame_start;
    logic          slot_end;
    logic [4:0]    nxt_slot;
    logic          nxt_c;
    logic [3:0]    nxt_b;
    logic [3:0]    bit_idx;

    logic [15:0]   word_l;
    logic [15:0]   word_r;
    logic [15:0]   eff_l;
    logic [15:0]   eff_r;
    logic          mute_lat;
    logic          underrun_q;
    logic          sdin_q;
    logic          sdin_nxt;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [31:0]   mem [FDEPTH];
    logic [31:0]   rd_data;
    logic          empty;
    logic          full;
    logic          push;

    assign ctr_nxt     = ctr + 1'b1;
    assign frame_start = &ctr;
    assign slot_end    = &ctr[SCLK_SH:0];

    // Slot that begins right after this edge: {channel, index within half-frame}.
    assign nxt_slot = ctr_nxt[CW-1:SCLK_SH+1];
    assign nxt_c    = nxt_slot[4];
    assign nxt_b    = nxt_slot[3:0];
    assign bit_idx  = 4'(5'd16 - {1'b0, nxt_b});

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign snd_rdy = ~full;
    assign push    = snd_we & ~full;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // A muted frame keeps stale words in the registers; gating here makes it silent.
    assign eff_l = mute_lat ? 16'h0000 : word_l;
    assign eff_r = mute_lat ? 16'h0000 : word_r;

    // NOTE: every variable assigned in always_comb gets a default first, so no path
    // leaves it holding a value and a latch can never be inferred.
    always_comb begin
        sdin_nxt = 1'b0;
        if (nxt_b == 4'd0) begin
            sdin_nxt = nxt_c ? eff_l[0] : eff_r[0];
        end else begin
            sdin_nxt = nxt_c ? eff_r[bit_idx] : eff_l[bit_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; later assignments in the block override earlier ones (flush beats push).
    always_ff @(negedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            ctr        <= '0;
            mute_lat   <= 1'b0;
            underrun_q <= 1'b0;
            word_l     <= '0;
            word_r     <= '0;
            sdin_q     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            ctr <= ctr_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (clr) begin
                underrun_q <= 1'b0;
            end
            if (slot_end) begin
                sdin_q <= sdin_nxt;
            end
            if (frame_start) begin
                mute_lat <= mute;
                if (mute) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else if (!empty) begin
                    {word_l, word_r} <= rd_data;
                    rd_ptr           <= rd_ptr + 1'b1;
                end else begin
                    word_l     <= '0;
                    word_r     <= '0;
                    underrun_q <= 1'b1;
                end
            end
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(negedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {snd_l, snd_r};
        end
    end

    assign underrun = underrun_q;
    assign dac_mclk = ctr[MCLK_SH];
    assign dac_sclk = ctr[SCLK_SH];
    assign dac_lrck = ctr[SCLK_SH+5];
    assign dac_sdin = sdin_q;

endmodule

// File: tb/tb_dac_i2s_tx.sv
// Bench for dac_i2s_tx: a frame-level model queues the expected serial bits, a monitor
// compares them at mid-slot; directed checks cover flags, FIFO level and reset.
module tb_dac_i2s_tx;

    localparam int FDEPTH = 4;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [15:0] snd_l = '0;
    logic [15:0] snd_r = '0;
    logic        snd_we = 1'b0;
    logic        mute = 1'b0;
    logic        clr = 1'b0;
    logic        snd_rdy, underrun, dac_mclk, dac_sclk, dac_lrck, dac_sdin;

    dac_i2s_tx #(.MCLK_SH(1), .SCLK_SH(3), .FDEPTH(FDEPTH)) dut (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .snd_l    (snd_l),
        .snd_r    (snd_r),
        .snd_we   (snd_we),
        .snd_rdy  (snd_rdy),
        .mute     (mute),
        .clr      (clr),
        .underrun (underrun),
        .dac_mclk (dac_mclk),
        .dac_sclk (dac_sclk),
        .dac_lrck (dac_lrck),
        .dac_sdin (dac_sdin)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    typedef struct packed {
        logic       b;
        logic [7:0] frame;
        logic [5:0] slot;
    } exp_t;

    function automatic exp_t mk(input logic b, input int frame, input int slot);
        exp_t e;
        e.b     = b;
        e.frame = 8'(frame);
        e.slot  = 6'(slot);
        return e;
    endfunction

    // Time base (bench-owned frame position), FIFO model and expected-bit queue.
    logic [8:0]  mctr = '0;
    logic [31:0] mdl_q[$];
    exp_t        exp_q[$];
    logic        prev_r = 1'b0;
    int          frame_no = 0;
    logic        fs, full0, empty0;
    logic [31:0] w;

    always @(negedge clk) begin
        if (sys_rst) begin
            mctr = '0;
            mdl_q.delete();
            exp_q.delete();
            prev_r = 1'b0;
            frame_no = 0;
        end else begin
            fs     = (mctr == 9'd511);
            full0  = (mdl_q.size() == FDEPTH);
            empty0 = (mdl_q.size() == 0);
            if (fs) begin
                w = '0;
                if (mute) mdl_q.delete();
                else if (!empty0) w = mdl_q.pop_front();
                frame_no++;
                exp_q.push_back(mk(prev_r, frame_no, 0));
                for (int b = 1; b < 16; b++) exp_q.push_back(mk(w[32-b], frame_no, b));
                exp_q.push_back(mk(w[16], frame_no, 16));
                for (int b = 1; b < 16; b++) exp_q.push_back(mk(w[16-b], frame_no, 16 + b));
                prev_r = w[0];
            end
            if (snd_we && !full0 && !(fs && mute)) mdl_q.push_back({snd_l, snd_r});
            mctr = mctr + 1'b1;
        end
    end

    exp_t e;
    always @(posedge clk) begin
        if (!sys_rst) begin
            check("clocks", {29'd0, dac_mclk, dac_sclk, dac_lrck}, {29'd0, mctr[1], mctr[3], mctr[8]});
            if (mctr[3:0] == 4'd8 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("sdin f%0d slot%0d", e.frame, e.slot), {31'd0, dac_sdin}, {31'd0, e.b});
            end
        end
    end

    task automatic wait_ctr(input logic [8:0] v);
        while (mctr != v) @(posedge clk);
    endtask

    task automatic next_frame();
        @(posedge clk);
        wait_ctr(9'd0);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        snd_l  = l;
        snd_r  = r;
        snd_we = 1'b1;
        @(posedge clk);
        snd_we = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        clr = 1'b0;
        @(posedge clk);
    endtask

    logic [7:0] mclk_pat = 8'b0110_0110;

    initial begin
        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst dac outputs", {28'd0, dac_mclk, dac_sclk, dac_lrck, dac_sdin}, 32'd0);
        check("rst snd_rdy", {31'd0, snd_rdy}, 32'd1);
        check("rst underrun", {31'd0, underrun}, 32'd0);
        @(posedge clk);
        sys_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            check($sformatf("mclk cycle %0d", k + 1), {31'd0, dac_mclk}, {31'd0, mclk_pat[k]});
        end

        // Single frame before the first frame start
        push(16'h8001, 16'h7FFE);
        check("rdy one queued", {31'd0, snd_rdy}, 32'd1);
        next_frame();

        // Fill the FIFO, then a write refused on the pop cycle
        wait_ctr(9'd20);
        push(16'h1234, 16'hABCD);
        push(16'hFFFF, 16'h0000);
        push(16'h0F0F, 16'hF0F0);
        check("rdy three queued", {31'd0, snd_rdy}, 32'd1);
        push(16'h5555, 16'hAAAA);
        check("rdy full", {31'd0, snd_rdy}, 32'd0);
        push(16'hDEAD, 16'hBEEF);
        check("rdy full after drop", {31'd0, snd_rdy}, 32'd0);
        wait_ctr(9'd511);
        push(16'hDEAD, 16'hBEEF);
        check("rdy after pop, full write refused", {31'd0, snd_rdy}, 32'd1);
        repeat (3) next_frame();
        wait_ctr(9'd100);
        check("no underrun while fed", {31'd0, underrun}, 32'd0);

        // Underrun, clear, re-set
        next_frame();
        wait_ctr(9'd100);
        check("underrun set", {31'd0, underrun}, 32'd1);
        pulse_clr();
        check("underrun cleared", {31'd0, underrun}, 32'd0);
        next_frame();
        wait_ctr(9'd50);
        check("underrun set again", {31'd0, underrun}, 32'd1);

        // Mute mid-frame with 3 queued: current frame intact, next flushed
        push(16'h0001, 16'h8000);
        push(16'h2222, 16'h3333);
        push(16'h4444, 16'h5555);
        next_frame();
        wait_ctr(9'd100);
        mute = 1'b1;
        check("rdy two queued", {31'd0, snd_rdy}, 32'd1);
        next_frame();
        wait_ctr(9'd50);
        pulse_clr();
        check("underrun cleared while muted", {31'd0, underrun}, 32'd0);
        push(16'h6666, 16'h7777);
        check("push accepted while muted", {31'd0, snd_rdy}, 32'd1);
        next_frame();
        wait_ctr(9'd50);
        mute = 1'b0;
        check("muted start no underrun", {31'd0, underrun}, 32'd0);
        wait_ctr(9'd511);
        clr = 1'b1;
        @(posedge clk);
        clr = 1'b0;
        check("underrun set beats clr", {31'd0, underrun}, 32'd1);

        // Reset mid-frame at left slot 7
        wait_ctr(9'd20);
        push(16'h1357, 16'h2468);
        push(16'h9999, 16'h8888);
        next_frame();
        wait_ctr(9'd126);
        #2;
        sys_rst = 1'b1;
        #1;
        check("async reset dac outputs", {28'd0, dac_mclk, dac_sclk, dac_lrck, dac_sdin}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset snd_rdy", {31'd0, snd_rdy}, 32'd1);
        check("reset underrun", {31'd0, underrun}, 32'd0);
        check("reset dac held", {28'd0, dac_mclk, dac_sclk, dac_lrck, dac_sdin}, 32'd0);
        @(posedge clk);
        sys_rst = 1'b0;
        wait_ctr(9'd100);
        check("no underrun before first start", {31'd0, underrun}, 32'd0);
        next_frame();
        wait_ctr(9'd50);
        check("fifo empty after reset", {31'd0, underrun}, 32'd1);

        // Push on the frame-start cycle into an empty FIFO: no bypass
        pulse_clr();
        check("underrun cleared again", {31'd0, underrun}, 32'd0);
        wait_ctr(9'd511);
        push(16'hC003, 16'h3FFD);
        wait_ctr(9'd50);
        check("push at start no bypass", {31'd0, underrun}, 32'd1);
        next_frame();
        next_frame();
        wait_ctr(9'd40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
